// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load handshake, selectable bit order
// and back-to-back framing. Define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_serializer #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [MSB-1:0] din,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           dir,
  input  logic           en,
  output logic           sout,
  output logic           sout_valid,
  output logic           last
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = MSB + 1;
`else
  localparam int FRAME_LEN = MSB;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state_reg;
  logic [MSB-1:0] shift_reg;
  logic           dir_reg;
  logic [CW-1:0]  count_reg;
  logic           data_bit;
  logic           accept;
`ifdef PISO_PARITY_EN
  logic           parity_reg;
`endif

  // The outgoing bit always sits at the end of the register that matches the captured order.
  assign data_bit   = dir_reg ? shift_reg[MSB-1] : shift_reg[0];
  assign sout_valid = (state_reg == SHIFT);
  assign last       = (state_reg == SHIFT) && (count_reg == CW'(FRAME_LEN - 1));
  assign load_ready = (state_reg == IDLE) || (last && en);
  assign accept     = load_valid && load_ready;

`ifdef PISO_PARITY_EN
  assign sout = sout_valid && ((count_reg == CW'(MSB)) ? parity_reg : data_bit);
`else
  assign sout = sout_valid && data_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      dir_reg    <= 1'b0;
      count_reg  <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (accept) begin
      state_reg  <= SHIFT;
      shift_reg  <= din;
      dir_reg    <= dir;
      count_reg  <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= ^din;
`endif
    end else if (state_reg == SHIFT && en) begin
      if (last) begin
        // Frame done with nothing waiting: drop back to a clean idle.
        state_reg <= IDLE;
        shift_reg <= '0;
        count_reg <= '0;
      end else begin
        shift_reg <= dir_reg ? {shift_reg[MSB-2:0], 1'b0} : {1'b0, shift_reg[MSB-1:1]};
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule
